router_out_arb: RTL
===================

# router_out_arb

Output-side scheduler for the 1x3 router. It watches the three output FIFOs' `vld_out_x` flags and drains one whole packet at a time through `read_enb_x` onto a single shared downstream byte link with ready/valid flow control, granting ports round-robin. It sits between the router top-level outputs and the shared link. It is packet-aware: it decodes each header byte to know when the packet ends, and it flags ports that wait too long, because the router soft-resets a FIFO that is left unread.

## Interface
Parameters:
- `MAX_WAIT`, default 24: cycles a requesting port may wait ungranted, or a granted port may stall empty, before its flag fires. Legal range 2..29, kept below the router's 30-cycle soft-reset window.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `vld_out_0/1/2` in 1: FIFO x non-empty.
- `data_out_0/1/2` in 8: FIFO x read data, valid the cycle after `read_enb_x`.
- `read_enb_0/1/2` out 1: FIFO x read strobe.
- `link_ready` in 1: downstream accepts a beat this cycle.
- `link_valid` out 1: beat present.
- `link_data` out 8: beat byte.
- `link_sop` out 1: beat is the header.
- `link_eop` out 1: beat is the parity byte.
- `link_port` out 2: source port of the beat (0..2).
- `starve` out 3: sticky per-port wait-timeout flag, cleared when that port is granted.
- `abort` out 1: one-cycle pulse, packet abandoned.
- `link_perr` out 1: parity mismatch, qualified by the `link_eop` beat (see Configuration).

## Operation
- Packet format: header byte, where `[7:2]` is payload length L (0..63) and `[1:0]` is the address. Then L payload bytes, then 1 parity byte. Total is L+2 reads.
- States: IDLE, HDR, BODY.
- **IDLE**
  - Choose the first port with `vld_out` high, scanning from `last+1` mod 3.
  - Register the grant, set `last`, go to HDR.
  - If no port has `vld_out` high, stay in IDLE.
- **HDR**
  - Issue one read on the granted port.
  - When the header byte returns, load `remaining = L+1`.
  - Go to BODY.
- **BODY**
  - Issue reads while `remaining > 0`, decrementing `remaining` per read.
  - After the last read is issued, go to IDLE. Arbitration for the next packet overlaps the drain of the current one.
- **Read-issue rule**
  - `read_enb_g` is high only when the granted `vld_out_g` is high and skid occupancy plus reads in flight (0 or 1) is at most 1.
  - Only the granted port is ever read. At most one `read_enb` is high per cycle.
- **Skid buffer**
  - 2 entries. Each returned byte is pushed with its sop/eop/port tags.
  - The head drives the `link_*` outputs. A beat pops on `link_valid & link_ready`.
- **Starve counters**
  - Per port. Increment while `vld_out_x` is high and port x is not granted.
  - At `MAX_WAIT`, set `starve[x]`.
  - Counter and flag clear on grant to x.
- **Stall abort**
  - Runs while in HDR/BODY with `vld_out_g` low. This covers a FIFO soft-reset mid-packet.
  - A stall counter counts those cycles. At `MAX_WAIT`, pulse `abort` and return to IDLE.
  - Beats already queued still drain. No `link_eop` is generated.
- **Reset**: reset mid-operation discards skid contents and in-flight data. No partial beats appear after reset.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE.
  - `last` = 2, so port 0 wins first.
  - All counters 0.
- Latency, with the link idle and `link_ready` high:
  - `vld_out_x` seen in IDLE at cycle c.
  - `read_enb_x` high at c+1.
  - Header on the link (`link_valid`, `link_sop`) at c+3.
- Throughput: with `link_ready` held high, one beat per cycle through the body.
- Backpressure:
  - `link_*` outputs are stable while `link_valid & !link_ready`.
  - No FIFO byte is lost; the skid absorbs the one in-flight read.
- L=0: header is followed immediately by parity; `link_sop` and `link_eop` appear on consecutive beats.
- Simultaneous requests on all ports resolve strictly round-robin (0,1,2,0,...).

## Configuration
- `ROUTER_ARB_PARITY_CHK_EN` defined:
  - XOR the header and payload bytes per packet.
  - Compare the result with the parity byte.
  - Drive `link_perr=1` coincident with the `link_eop` beat on mismatch.
- Undefined: `link_perr` is tied 0 and no checker logic is built.

## Structure
- Shared package `router_pkg`:
  - state enum (IDLE/HDR/BODY)
  - `PORTS=3`
  - header field positions (`LEN_MSB=7`, `LEN_LSB=2`)
  - beat struct {data, sop, eop, port}
- Sub-module `router_skid`: 2-entry tagged skid FIFO with count output.

## Test plan
- Single packet: port 1, L=4, `link_ready` held 1 → `read_enb_1` high for 6 consecutive cycles from c+1. Link carries 6 beats; sop on the first, eop on the sixth, `link_port`=1, header at c+3.
- Contention: all three ports loaded with L=2 → packets leave in order 0,1,2. Then, reloading port 0 and port 2 → order 0,2.
- Backpressure: L=10 with `link_ready` toggling 1,0 → all 12 bytes arrive in order with no duplicates, and `link_*` outputs hold during every low-ready cycle.
- Starvation: port 2 kept busy behind two L=63 packets on ports 0/1 → `starve[2]` asserts after 24 waiting cycles and clears on the grant to port 2.
- Abort: `vld_out_0` dropped after 3 of 8 bytes and held low → `abort` pulses 24 cycles later, state returns to IDLE, and the next port is served.
- Parity (macro on): wrong parity byte → `link_perr`=1 on the eop beat. Correct parity byte → 0.

Source files
------------

// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module   : router_pkg
// Purpose  : Shared types, header field positions and round-robin helper for
//            the router output scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package router_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } state_t;

    localparam int PORTS   = 3;
    localparam int LEN_MSB = 7;
    localparam int LEN_LSB = 2;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic [1:0] port;
    } beat_t;

    // Returns {found, port}: first requester scanning from last+1 mod 3.
    function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] cand;
        res = 3'b000;
        for (int i = 1; i <= 3; i++) begin
            cand = 2'((32'(last) + i) % 3);
            if (!res[2] && req[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/router_skid.sv
`default_nettype none
// ============================================================================
// Module   : router_skid
// Purpose  : Two-entry tagged skid FIFO; the head entry drives the link.
// Revision : 1.0 - initial release
// ============================================================================
module router_skid
    import router_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  beat_t      push_beat,
    input  logic       pop,
    output beat_t      head,
    output logic [1:0] count
);

    beat_t      r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;
    logic       w_pop;

    assign w_pop = pop && (r_count != 2'd0);
    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_beat;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, push} - {1'b0, w_pop};
        end
    end

endmodule
`default_nettype wire

// File: rtl/router_out_arb.sv
`default_nettype none
// ============================================================================
// Module   : router_out_arb
// Purpose  : Packet-aware round-robin drain of three router FIFOs onto one
//            ready/valid byte link. Optional parity check: ROUTER_ARB_PARITY_CHK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module router_out_arb
    import router_pkg::*;
#(
    parameter int MAX_WAIT = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vld_out_0,
    input  logic       vld_out_1,
    input  logic       vld_out_2,
    input  logic [7:0] data_out_0,
    input  logic [7:0] data_out_1,
    input  logic [7:0] data_out_2,
    output logic       read_enb_0,
    output logic       read_enb_1,
    output logic       read_enb_2,
    input  logic       link_ready,
    output logic       link_valid,
    output logic [7:0] link_data,
    output logic       link_sop,
    output logic       link_eop,
    output logic [1:0] link_port,
    output logic [2:0] starve,
    output logic       abort,
    output logic       link_perr
);

    localparam logic [4:0] c_WAIT_MAX  = 5'(MAX_WAIT);
    localparam logic [4:0] c_STALL_END = 5'(MAX_WAIT - 1);

    state_t     r_state;
    logic [1:0] r_grant;
    logic [1:0] r_last;
    logic       r_pend;
    logic       r_pend_sop;
    logic       r_pend_eop;
    logic [1:0] r_pend_port;
    logic [6:0] r_rem;
    logic       r_rem_vld;
    logic [4:0] r_stall;
    logic       r_abort;

    logic [2:0] w_vld;
    logic       w_vld_g;
    logic [7:0] w_pend_data;
    logic [2:0] w_pick_res;
    logic       w_found;
    logic [1:0] w_pick;
    logic       w_grant_evt;
    logic       w_busy;
    logic [1:0] w_cnt;
    logic       w_pop;
    logic [2:0] w_occ;
    logic [6:0] w_rem;
    logic       w_issue;
    logic       w_last;
    logic       w_stall;
    beat_t      w_push_beat;
    beat_t      w_head;
    logic [2:0] w_starve;

    assign w_vld = {vld_out_2, vld_out_1, vld_out_0};

    always_comb begin
        w_vld_g     = 1'b0;
        w_pend_data = 8'd0;
        case (r_grant)
            2'd0:    w_vld_g = vld_out_0;
            2'd1:    w_vld_g = vld_out_1;
            2'd2:    w_vld_g = vld_out_2;
            default: w_vld_g = 1'b0;
        endcase
        case (r_pend_port)
            2'd0:    w_pend_data = data_out_0;
            2'd1:    w_pend_data = data_out_1;
            2'd2:    w_pend_data = data_out_2;
            default: w_pend_data = 8'd0;
        endcase
    end

    assign w_pick_res  = rr_pick(w_vld, r_last);
    assign w_found     = w_pick_res[2];
    assign w_pick      = w_pick_res[1:0];
    assign w_grant_evt = (r_state == IDLE) && w_found;
    assign w_busy      = (r_state != IDLE);

    // Credit check counts this cycle's pop so reads can stream back-to-back.
    assign w_pop   = link_valid && link_ready;
    assign w_occ   = {1'b0, w_cnt} - {2'b00, w_pop} + {2'b00, r_pend};
    // Until the header lands in r_rem, it is on the read-data bus this cycle.
    assign w_rem   = r_rem_vld ? r_rem : ({1'b0, w_pend_data[LEN_MSB:LEN_LSB]} + 7'd1);
    assign w_issue = w_busy && w_vld_g && (w_occ <= 3'd1);
    assign w_last  = (r_state == BODY) && (w_rem == 7'd1);
    assign w_stall = w_busy && !w_vld_g;

    assign read_enb_0 = w_issue && (r_grant == 2'd0);
    assign read_enb_1 = w_issue && (r_grant == 2'd1);
    assign read_enb_2 = w_issue && (r_grant == 2'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_grant     <= 2'd0;
            r_last      <= 2'd2;
            r_pend      <= 1'b0;
            r_pend_sop  <= 1'b0;
            r_pend_eop  <= 1'b0;
            r_pend_port <= 2'd0;
            r_rem       <= 7'd0;
            r_rem_vld   <= 1'b0;
            r_stall     <= 5'd0;
            r_abort     <= 1'b0;
        end else begin
            r_abort <= 1'b0;
            r_pend  <= w_issue;
            if (w_issue) begin
                r_pend_port <= r_grant;
                r_pend_sop  <= (r_state == HDR);
                r_pend_eop  <= w_last;
            end
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant   <= w_pick;
                        r_last    <= w_pick;
                        r_rem_vld <= 1'b0;
                        r_stall   <= 5'd0;
                        r_state   <= HDR;
                    end
                end
                HDR: begin
                    if (w_issue) begin
                        r_state <= BODY;
                    end
                end
                BODY: begin
                    if (!r_rem_vld) begin
                        r_rem     <= w_rem - {6'd0, w_issue};
                        r_rem_vld <= 1'b1;
                    end else if (w_issue) begin
                        r_rem <= r_rem - 7'd1;
                    end
                    if (w_issue && w_last) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (w_stall) begin
                if (r_stall == c_STALL_END) begin
                    r_abort <= 1'b1;
                    r_stall <= 5'd0;
                    r_state <= IDLE;
                end else begin
                    r_stall <= r_stall + 5'd1;
                end
            end else if (w_busy) begin
                r_stall <= 5'd0;
            end
        end
    end

    always_comb begin
        w_push_beat      = '0;
        w_push_beat.data = w_pend_data;
        w_push_beat.sop  = r_pend_sop;
        w_push_beat.eop  = r_pend_eop;
        w_push_beat.port = r_pend_port;
    end

    router_skid u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (r_pend),
        .push_beat (w_push_beat),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_cnt)
    );

    assign link_valid = (w_cnt != 2'd0);
    assign link_data  = link_valid ? w_head.data : 8'd0;
    assign link_sop   = link_valid && w_head.sop;
    assign link_eop   = link_valid && w_head.eop;
    assign link_port  = link_valid ? w_head.port : 2'd0;
    assign abort      = r_abort;
    assign starve     = w_starve;

    for (genvar x = 0; x < PORTS; x++) begin : g_starve
        logic [4:0] r_wait;
        logic       r_flag;
        always_ff @(posedge clk) begin
            if (reset) begin
                r_wait <= 5'd0;
                r_flag <= 1'b0;
            end else if (w_grant_evt && (w_pick == 2'(x))) begin
                r_wait <= 5'd0;
                r_flag <= 1'b0;
            end else if (w_vld[x] && !(w_busy && (r_grant == 2'(x)))) begin
                if (r_wait < c_WAIT_MAX) begin
                    r_wait <= r_wait + 5'd1;
                end
                if (r_wait == c_STALL_END) begin
                    r_flag <= 1'b1;
                end
            end
        end
        assign w_starve[x] = r_flag;
    end

`ifdef ROUTER_ARB_PARITY_CHK_EN
    // Running XOR of header+payload beats as they leave; compared at the eop head.
    logic [7:0] r_par_acc;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_par_acc <= 8'd0;
        end else if (w_pop) begin
            if (w_head.sop) begin
                r_par_acc <= w_head.data;
            end else if (!w_head.eop) begin
                r_par_acc <= r_par_acc ^ w_head.data;
            end
        end
    end
    assign link_perr = link_valid && w_head.eop && (r_par_acc != w_head.data);
`else
    assign link_perr = 1'b0;
`endif

endmodule
`default_nettype wire
